// File: rtl/mem_flash_loader_pkg.sv
// Shared types and constants for the flash boot loader.
// States, word geometry and length-field width.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_BITS = 16;

endpackage

// File: rtl/mem_flash_loader_word_packer.sv
// Byte-lane insert register for little-endian word assembly.
// word shows the stored bytes with the incoming byte already merged.
module word_packer
  import flash_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] word
);

  logic [31:0] data_q;

  always_comb begin
    word = data_q;
    if (byte_en) word[8*lane +: 8] = byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) data_q <= '0;
    else            data_q <= word;
  end

endmodule

// File: rtl/mem_flash_loader.sv
// UART-fed boot loader: length header, packed word writes
// to the flash port, trailing XOR checksum, CPU held in reset.
module mem_flash_loader
  import flash_loader_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  ADDR_BASE = '0,
  parameter int                MAX_WORDS = 2048
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam logic [COUNT_BITS-1:0] MAX_CNT =
    COUNT_BITS'(MAX_WORDS);
  localparam logic [1:0] LAST_LANE =
    2'(BYTES_PER_WORD - 1);

  loader_state_t         state;
  logic [COUNT_BITS-1:0] count;
  logic [COUNT_BITS-1:0] word_idx;
  logic [COUNT_BITS-1:0] len;
  logic [1:0]            byte_cnt;
  logic [7:0]            csum;
  logic [31:0]           pk_word;
  logic                  xfer;
  logic                  idle_like;
  logic                  go;

  assign idle_like = (state == IDLE) || (state == DONE)
                  || (state == ERROR);
  assign go        = idle_like && start;
  assign rx_ready  = (state == LEN0) || (state == LEN1)
                  || (state == DATA) || (state == CHK);
  assign cpu_hold  = !idle_like;
  assign xfer      = rx_valid && rx_ready;
  assign len       = {rx_data, count[7:0]};

  word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (go),
    .byte_en (xfer && (state == DATA)),
    .lane    (byte_cnt),
    .byte_in (rx_data),
    .word    (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      flash_en   <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      flash_en <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state    <= LEN0;
            done     <= 1'b0;
            error    <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
            csum     <= '0;
          end
        end
        LEN0: begin
          if (xfer) begin
            count[7:0] <= rx_data;
            csum       <= csum ^ rx_data;
            state      <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            count[15:8] <= rx_data;
            csum        <= csum ^ rx_data;
            if (len == '0) begin
              state <= CHK;
            end else if (len > MAX_CNT) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == LAST_LANE) begin
              // flash regs load here so they are valid in WRITE
              state      <= WRITE;
              flash_en   <= 1'b1;
              flash_data <= WIDTH'(pk_word);
              flash_addr <= ADDR_BASE
                          + WIDTH'({word_idx, 2'b00});
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (word_idx + 1'b1 == count) state <= CHK;
          else                          state <= DATA;
        end
        CHK: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_flash_loader.sv
// Scoreboard bench for mem_flash_loader: expected writes
// are queued as bytes are driven and popped on flash_en.
module tb_mem_flash_loader;

  localparam int MAXW = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        flash_en;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;
  int n_writes = 0;
  int bad_rdy  = 0;
  int cyc      = 0;
  int last_acc = 0;
  int last_we  = 0;
  int first_dat = 0;
  bit g_gaps   = 1'b0;

  logic [63:0] wq[$];
  logic [31:0] wdata[0:3];

  mem_flash_loader #(
    .WIDTH     (32),
    .ADDR_BASE (32'h0),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .flash_en   (flash_en),
    .flash_addr (flash_addr),
    .flash_data (flash_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  // write monitor and handshake invariants
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_hold && (rx_ready == flash_en)) bad_rdy++;
      if (!cpu_hold && (rx_ready || flash_en)) bad_rdy++;
    end
    if (flash_en) begin
      n_writes++;
      last_we = cyc;
      if (wq.size() == 0) begin
        check("spurious_write", {31'b0, flash_en}, 32'd0);
      end else begin
        logic [63:0] e;
        e = wq.pop_front();
        check("write_addr", flash_addr, e[63:32]);
        check("write_data", flash_data, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b,
                           input bit st);
    int t;
    t = 0;
    @(negedge clk);
    start = 1'b0;
    while (g_gaps && ($urandom_range(0, 1) == 0)) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    start    = st;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rx_ready_wait", {31'b0, rx_ready}, 32'd1);
    last_acc = cyc;
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    while (cpu_hold && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("load_end_hold", {31'b0, cpu_hold}, 32'd0);
  endtask

  task automatic do_load(input logic [15:0] cnt,
                         input bit bad,
                         input int start_at);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    @(negedge clk);
    start = 1'b1;
    send_byte(cnt[7:0], 1'b0);
    cs ^= cnt[7:0];
    send_byte(cnt[15:8], 1'b0);
    cs ^= cnt[15:8];
    if (cnt <= 16'(MAXW)) begin
      for (int w = 0; w < int'(cnt); w++) begin
        wq.push_back({32'(w * 4), wdata[w]});
        for (int k = 0; k < 4; k++) begin
          b = wdata[w][8*k +: 8];
          send_byte(b, (w * 4 + k) == start_at);
          if (w == 0 && k == 0) first_dat = last_acc;
          cs ^= b;
        end
      end
      send_byte(bad ? ~cs : cs, 1'b0);
    end
    wait_idle();
  endtask

  initial begin
    int nw;
    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_hold",  {31'b0, cpu_hold}, 32'd0);
    check("rst_flags", {30'b0, done, error}, 32'd0);
    check("rst_we",    {31'b0, flash_en}, 32'd0);
    rst = 1'b0;

    // single word, checksum 0x23
    wdata[0] = 32'hDEADBEEF;
    nw = n_writes;
    do_load(16'd1, 1'b0, -1);
    check("t1_writes", 32'(n_writes - nw), 32'd1);
    check("t1_done",   {30'b0, done, error}, 32'd2);

    // three words back-to-back, timing
    wdata[0] = 32'h1;
    wdata[1] = 32'h2;
    wdata[2] = 32'h3;
    nw = n_writes;
    do_load(16'd3, 1'b0, -1);
    check("t2_writes", 32'(n_writes - nw), 32'd3);
    check("t2_span", 32'(last_we - first_dat + 1), 32'd15);
    check("t2_done", {30'b0, done, error}, 32'd2);

    // bad checksum
    wdata[0] = 32'hA5A50001;
    wdata[1] = 32'h12345678;
    nw = n_writes;
    do_load(16'd2, 1'b1, -1);
    check("t3_writes", 32'(n_writes - nw), 32'd2);
    check("t3_error",  {30'b0, done, error}, 32'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_err_clr", {30'b0, done, error}, 32'd0);
    check("t3_len0_rdy", {31'b0, rx_ready}, 32'd1);

    // oversize count (start is ignored in LEN0)
    nw = n_writes;
    do_load(16'h0801, 1'b0, -1);
    check("t4_big_wr",  32'(n_writes - nw), 32'd0);
    check("t4_big_err", {30'b0, done, error}, 32'd1);
    do_load(16'h0000, 1'b0, -1);
    check("t4_zero_wr", 32'(n_writes - nw), 32'd0);
    check("t4_zero_ok", {30'b0, done, error}, 32'd2);

    // reset mid-load during 2nd word
    wdata[0] = 32'h11223344;
    wdata[1] = 32'h55667788;
    @(negedge clk);
    start = 1'b1;
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    wq.push_back({32'h0, wdata[0]});
    for (int k = 0; k < 4; k++)
      send_byte(wdata[0][8*k +: 8], 1'b0);
    send_byte(wdata[1][7:0], 1'b0);
    send_byte(wdata[1][15:8], 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("t5_we",   {31'b0, flash_en}, 32'd0);
    check("t5_rdy",  {31'b0, rx_ready}, 32'd0);
    check("t5_hold", {31'b0, cpu_hold}, 32'd0);
    check("t5_flag", {30'b0, done, error}, 32'd0);
    check("t5_addr", flash_addr, 32'd0);
    check("t5_data", flash_data, 32'd0);
    check("t5_q", 32'(wq.size()), 32'd0);
    rst = 1'b0;
    wdata[0] = 32'hCAFEF00D;
    wdata[1] = 32'h0BADC0DE;
    nw = n_writes;
    do_load(16'd2, 1'b0, -1);
    check("t5_writes", 32'(n_writes - nw), 32'd2);
    check("t5_done",   {30'b0, done, error}, 32'd2);

    // random gaps and a stray start mid-load
    wdata[0] = 32'h1;
    wdata[1] = 32'h2;
    wdata[2] = 32'h3;
    g_gaps = 1'b1;
    nw = n_writes;
    do_load(16'd3, 1'b0, 6);
    g_gaps = 1'b0;
    check("t6_writes", 32'(n_writes - nw), 32'd3);
    check("t6_done",   {30'b0, done, error}, 32'd2);

    check("q_empty", 32'(wq.size()), 32'd0);
    check("ready_rule", 32'(bad_rdy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
